// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: idle ops, FSM states
// and the per-bit next-value select used by shift_cell.
package univ_shift_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // LEFT takes the lower-index neighbour (shift toward MSB), RIGHT the upper.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LEFT  = 2'b01,
    SEL_RIGHT = 2'b10,
    SEL_LOAD  = 2'b11
  } sel_e;

endpackage

// File: rtl/shift_cell.sv
// One register bit: 4:1 next-value mux (hold / left / right / load) into a
// flop with synchronous active-high reset.
module shift_cell
  import univ_shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sel_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       d_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel_e'(sel_i))
      SEL_HOLD:  q_d = q_q;
      SEL_LEFT:  q_d = left_i;
      SEL_RIGHT: q_d = right_i;
      SEL_LOAD:  q_d = d_i;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register with idle ops and a load-then-serialise burst.
// Define UNIV_SHIFT_ROTATE_EN to let rot select rotate fill instead of Sin.
module univ_shift_register
  import univ_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   op,
  input  logic         Sin,
  input  logic         rot,
  input  logic [N-1:0] D,
  input  logic         start,
  input  logic         dir,
  output logic [N-1:0] Q,
  output logic         Sout,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_o
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sel_e          sel;
  logic          fill_shl;
  logic          fill_shr;
  logic [N-1:0]  q_bits;
  logic [N-1:0]  left_nb;
  logic [N-1:0]  right_nb;

`ifdef UNIV_SHIFT_ROTATE_EN
  // Rotate fill is the bit leaving the opposite end.
  assign fill_shl = rot ? q_bits[N-1] : Sin;
  assign fill_shr = rot ? q_bits[0]   : Sin;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_shl   = Sin;
  assign fill_shr   = Sin;
`endif

  assign left_nb  = {q_bits[N-2:0], fill_shl};
  assign right_nb = {fill_shr, q_bits[N-1:1]};

  for (genvar i = 0; i < N; i++) begin : g_cell
    shift_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .sel_i  (sel),
      .left_i (left_nb[i]),
      .right_i(right_nb[i]),
      .d_i    (D[i]),
      .q_o    (q_bits[i])
    );
  end

  // start wins over op in IDLE; SHIFT and DONE ignore both.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    sel     = SEL_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel     = SEL_LOAD;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          case (op_e'(op))
            OP_SHL: begin
              sel   = SEL_LEFT;
              dir_d = 1'b0;
            end
            OP_SHR: begin
              sel   = SEL_RIGHT;
              dir_d = 1'b1;
            end
            OP_LOAD: sel = SEL_LOAD;
            default: sel = SEL_HOLD;
          endcase
        end
      end
      ST_SHIFT: begin
        sel   = dir_q ? SEL_RIGHT : SEL_LEFT;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Q       = q_bits;
  assign Sout    = dir_q ? q_bits[0] : q_bits[N-1];
  assign busy    = (state_q == ST_SHIFT);
  assign done    = (state_q == ST_DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed bench for univ_shift_register at N=8: idle ops, bursts, start
// override, mid-burst reset and the rotate configuration.
module tb_univ_shift_register;

  logic       clk;
  logic       rst;
  logic [1:0] op;
  logic       Sin;
  logic       rot;
  logic [7:0] D;
  logic       start;
  logic       dir;
  logic [7:0] Q;
  logic       Sout;
  logic       busy;
  logic       done;
  logic [1:0] state_o;

  int tests_run;
  int tests_failed;

  univ_shift_register #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .Sin    (Sin),
    .rot    (rot),
    .D      (D),
    .start  (start),
    .dir    (dir),
    .Q      (Q),
    .Sout   (Sout),
    .busy   (busy),
    .done   (done),
    .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 2'b11; D = 8'hFF; start = 1'b1; dir = 1'b1; Sin = 1'b1;
    tick();
    tick();
    tests_run++;
    if (Q !== 8'h00) begin tests_failed++; $display("FAIL reset_q got=%h exp=00", Q); end
    tests_run++;
    if ({busy, done, Sout} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags got=%b exp=000", {busy, done, Sout});
    end
    tests_run++;
    if (state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    rst = 1'b0; op = 2'b00; D = 8'h00; start = 1'b0; dir = 1'b0; Sin = 1'b0;
  endtask

  task automatic test_load_hold();
    op = 2'b11; D = 8'hA5;
    tick();
    tests_run++;
    if (Q !== 8'hA5) begin tests_failed++; $display("FAIL load_q got=%h exp=a5", Q); end
    op = 2'b00; D = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (Q !== 8'hA5) begin tests_failed++; $display("FAIL hold_q cyc=%0d got=%h exp=a5", i, Q); end
    end
  endtask

  task automatic test_shl_shr();
    op = 2'b11; D = 8'h81;
    tick();
    op = 2'b01; Sin = 1'b0;
    tick();
    tests_run++;
    if (Q !== 8'h02 || Sout !== 1'b0) begin
      tests_failed++; $display("FAIL shl got Q=%h Sout=%b exp Q=02 Sout=0", Q, Sout);
    end
    op = 2'b10; Sin = 1'b1;
    tick();
    tests_run++;
    if (Q !== 8'h81 || Sout !== 1'b1) begin
      tests_failed++; $display("FAIL shr got Q=%h Sout=%b exp Q=81 Sout=1", Q, Sout);
    end
    op = 2'b00; Sin = 1'b0;
  endtask

  task automatic test_burst();
    logic [7:0] exp_seq;
    exp_seq = 8'b1100_0011;  // expected Sout, first cycle in bit 7
    op = 2'b00; D = 8'hC3; dir = 1'b0; Sin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (Sout !== exp_seq[7-k] || busy !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("FAIL burst_c3 k=%0d got Sout=%b busy=%b done=%b exp Sout=%b busy=1 done=0",
                 k, Sout, busy, done, exp_seq[7-k]);
      end
      tick();
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || Q !== 8'h00) begin
      tests_failed++; $display("FAIL burst_done got done=%b busy=%b Q=%h exp 1 0 00", done, busy, Q);
    end
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || state_o !== 2'd0) begin
      tests_failed++; $display("FAIL burst_after got done=%b busy=%b st=%0d exp 0 0 0", done, busy, state_o);
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_q;
`ifdef UNIV_SHIFT_ROTATE_EN
    exp_q = 8'h96;
`else
    exp_q = 8'h00;
`endif
    D = 8'h96; dir = 1'b0; Sin = 1'b0; rot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    tests_run++;
    if (done !== 1'b1 || Q !== exp_q) begin
      tests_failed++; $display("FAIL rotate_burst got done=%b Q=%h exp done=1 Q=%h", done, Q, exp_q);
    end
    rot = 1'b0;
    tick();
  endtask

  task automatic test_ignore_and_reset();
    D = 8'hF0; dir = 1'b1; Sin = 1'b0; start = 1'b1;
    tick();
    start = 1'b1; op = 2'b11; D = 8'hFF;
    tick();
    start = 1'b0; op = 2'b00;
    tests_run++;
    if (Q !== 8'h78 || busy !== 1'b1) begin
      tests_failed++; $display("FAIL midburst_ignore got Q=%h busy=%b exp Q=78 busy=1", Q, busy);
    end
    tick();
    tick();
    tests_run++;
    if (Q !== 8'h1E) begin tests_failed++; $display("FAIL three_shifts got=%h exp=1e", Q); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (Q !== 8'h00 || {busy, done, Sout} !== 3'b000) begin
      tests_failed++; $display("FAIL midburst_rst got Q=%h flags=%b exp Q=00 flags=000", Q, {busy, done, Sout});
    end
    D = 8'h5B; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (Q !== 8'h5B || busy !== 1'b1 || Sout !== 1'b1) begin
      tests_failed++; $display("FAIL restart got Q=%h busy=%b Sout=%b exp Q=5b busy=1 Sout=1", Q, busy, Sout);
    end
    for (int k = 0; k < 8; k++) tick();
    tests_run++;
    if (done !== 1'b1) begin tests_failed++; $display("FAIL restart_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_start_override();
    op = 2'b11; D = 8'h11;
    tick();
    op = 2'b01; D = 8'h3C; dir = 1'b0; Sin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; op = 2'b00; Sin = 1'b0;
    tests_run++;
    if (Q !== 8'h3C || busy !== 1'b1 || Sout !== 1'b0) begin
      tests_failed++; $display("FAIL start_override got Q=%h busy=%b Sout=%b exp Q=3c busy=1 Sout=0", Q, busy, Sout);
    end
    tick();
    tests_run++;
    if (Q !== 8'h78) begin tests_failed++; $display("FAIL override_shift got=%h exp=78", Q); end
    for (int k = 0; k < 8; k++) tick();
    tests_run++;
    if (state_o !== 2'd0 || Q !== 8'h00) begin
      tests_failed++; $display("FAIL override_end got st=%0d Q=%h exp st=0 Q=00", state_o, Q);
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; op = 2'b00; Sin = 1'b0; rot = 1'b0; D = 8'h00; start = 1'b0; dir = 1'b0;
    test_reset();
    test_load_hold();
    test_shl_shr();
    test_burst();
    test_rotate();
    test_ignore_and_reset();
    test_start_override();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
